// File: rtl/sc_frog_game_fsm.sv
// rtl/sc_frog_game_fsm.sv - Frogger game sequencer: frog position, lives, level and game phases.
module sc_frog_game_fsm #(
    parameter int ROWS       = 8,
    parameter int DATAWIDTH  = 8,
    parameter int START_COL  = 4,
    parameter int LIVES_INIT = 3,
    parameter int DEATH_WAIT = 25000000
) (
    input  logic                 SC_FROGFSM_CLOCK_50,
    input  logic                 SC_FROGFSM_RESET_InLow,
    input  logic                 SC_FROGFSM_start_InLow,
    input  logic                 SC_FROGFSM_up_InLow,
    input  logic                 SC_FROGFSM_down_InLow,
    input  logic                 SC_FROGFSM_left_InLow,
    input  logic                 SC_FROGFSM_right_InLow,
    input  logic                 SC_FROGFSM_bottomside_In,
    input  logic                 SC_FROGFSM_collision_In,
    output logic [2:0]           SC_FROGFSM_frogrow_Out,
    output logic [DATAWIDTH-1:0] SC_FROGFSM_frogcol_Out,
    output logic                 SC_FROGFSM_frogvisible_Out,
    output logic [1:0]           SC_FROGFSM_lives_Out,
    output logic [3:0]           SC_FROGFSM_level_Out,
    output logic                 SC_FROGFSM_clearboard_OutLow,
    output logic                 SC_FROGFSM_gameover_Out,
    output logic [2:0]           SC_FROGFSM_state_Out
);

    localparam int CNT_W = (DEATH_WAIT > 1) ? $clog2(DEATH_WAIT) : 1;
    localparam logic [DATAWIDTH-1:0] COL_START = {{(DATAWIDTH-1){1'b0}}, 1'b1} << START_COL;
    localparam logic [2:0]       ROW_GOAL   = 3'(ROWS - 1);
    localparam logic [1:0]       LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEATH_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAITCLEAR = 3'd1,
        S_SPAWN     = 3'd2,
        S_PLAY      = 3'd3,
        S_DEATH     = 3'd4,
        S_WIN       = 3'd5,
        S_GAMEOVER  = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           row_q, row_d;
    logic [DATAWIDTH-1:0] col_q, col_d;
    logic                 visible_q, visible_d;
    logic [1:0]           lives_q, lives_d;
    logic [3:0]           level_q, level_d;
    logic                 clear_n_q, clear_n_d;
    logic                 gameover_q, gameover_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic start, mv_up, mv_down, mv_left, mv_right;

    assign start    = ~SC_FROGFSM_start_InLow;
    assign mv_up    = ~SC_FROGFSM_up_InLow;
    assign mv_down  = ~SC_FROGFSM_down_InLow;
    assign mv_left  = ~SC_FROGFSM_left_InLow;
    assign mv_right = ~SC_FROGFSM_right_InLow;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        visible_d  = visible_q;
        lives_d    = lives_q;
        level_d    = level_q;
        clear_n_d  = 1'b1;
        gameover_d = gameover_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE, S_GAMEOVER: begin
                // A new game reloads the score and clears the board on the first WAITCLEAR cycle.
                if (start) begin
                    state_d    = S_WAITCLEAR;
                    lives_d    = LIVES_LOAD;
                    level_d    = 4'd0;
                    clear_n_d  = 1'b0;
                    gameover_d = 1'b0;
                end
            end
            S_WAITCLEAR: begin
                if (SC_FROGFSM_bottomside_In) begin
                    state_d = S_SPAWN;
                end
            end
            S_SPAWN: begin
                state_d   = S_PLAY;
                row_d     = 3'd0;
                col_d     = COL_START;
                visible_d = 1'b1;
            end
            S_PLAY: begin
                if (SC_FROGFSM_collision_In) begin
                    state_d   = S_DEATH;
                    lives_d   = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    visible_d = 1'b0;
                    cnt_d     = '0;
                end else if (mv_up) begin
                    row_d = row_q + 3'd1;
                    if (row_q + 3'd1 == ROW_GOAL) begin
                        state_d = S_WIN;
                    end
                end else if (mv_down) begin
                    if (row_q != 3'd0) begin
                        row_d = row_q - 3'd1;
                    end
                end else if (mv_left) begin
                    if (!col_q[DATAWIDTH-1]) begin
                        col_d = col_q << 1;
                    end
                end else if (mv_right) begin
                    if (!col_q[0]) begin
                        col_d = col_q >> 1;
                    end
                end
            end
            S_DEATH: begin
                if (cnt_q == CNT_LAST) begin
                    if (lives_q == 2'd0) begin
                        state_d    = S_GAMEOVER;
                        gameover_d = 1'b1;
                    end else begin
                        state_d = S_WAITCLEAR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WIN: begin
                state_d   = S_WAITCLEAR;
                level_d   = (level_q != 4'hF) ? level_q + 4'd1 : level_q;
                visible_d = 1'b0;
                clear_n_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SC_FROGFSM_CLOCK_50 or negedge SC_FROGFSM_RESET_InLow) begin
        if (!SC_FROGFSM_RESET_InLow) begin
            state_q    <= S_IDLE;
            row_q      <= 3'd0;
            col_q      <= COL_START;
            visible_q  <= 1'b0;
            lives_q    <= LIVES_LOAD;
            level_q    <= 4'd0;
            clear_n_q  <= 1'b1;
            gameover_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            visible_q  <= visible_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            clear_n_q  <= clear_n_d;
            gameover_q <= gameover_d;
            cnt_q      <= cnt_d;
        end
    end

    assign SC_FROGFSM_frogrow_Out       = row_q;
    assign SC_FROGFSM_frogcol_Out       = col_q;
    assign SC_FROGFSM_frogvisible_Out   = visible_q;
    assign SC_FROGFSM_lives_Out         = lives_q;
    assign SC_FROGFSM_level_Out         = level_q;
    assign SC_FROGFSM_clearboard_OutLow = clear_n_q;
    assign SC_FROGFSM_gameover_Out      = gameover_q;
    assign SC_FROGFSM_state_Out         = state_q;

endmodule

// File: tb/tb_sc_frog_game_fsm.sv
// tb/tb_sc_frog_game_fsm.sv - scoreboard bench for sc_frog_game_fsm against a game-rule model.
module tb_sc_frog_game_fsm;

    localparam int ROWS   = 8;
    localparam int DW     = 8;
    localparam int SCOL   = 4;
    localparam int LIVES  = 3;
    localparam int DWAIT  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_n = 1'b1, up_n = 1'b1, down_n = 1'b1, left_n = 1'b1, right_n = 1'b1;
    logic       bottom = 1'b0, coll = 1'b0;
    logic [2:0] row_o;
    logic [7:0] col_o;
    logic       vis_o;
    logic [1:0] lives_o;
    logic [3:0] level_o;
    logic       clr_n_o, go_o;
    logic [2:0] st_o;

    sc_frog_game_fsm #(
        .ROWS(ROWS), .DATAWIDTH(DW), .START_COL(SCOL), .LIVES_INIT(LIVES), .DEATH_WAIT(DWAIT)
    ) dut (
        .SC_FROGFSM_CLOCK_50         (clk),
        .SC_FROGFSM_RESET_InLow      (rst_n),
        .SC_FROGFSM_start_InLow      (start_n),
        .SC_FROGFSM_up_InLow         (up_n),
        .SC_FROGFSM_down_InLow       (down_n),
        .SC_FROGFSM_left_InLow       (left_n),
        .SC_FROGFSM_right_InLow      (right_n),
        .SC_FROGFSM_bottomside_In    (bottom),
        .SC_FROGFSM_collision_In     (coll),
        .SC_FROGFSM_frogrow_Out      (row_o),
        .SC_FROGFSM_frogcol_Out      (col_o),
        .SC_FROGFSM_frogvisible_Out  (vis_o),
        .SC_FROGFSM_lives_Out        (lives_o),
        .SC_FROGFSM_level_Out        (level_o),
        .SC_FROGFSM_clearboard_OutLow(clr_n_o),
        .SC_FROGFSM_gameover_Out     (go_o),
        .SC_FROGFSM_state_Out        (st_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st, row, col, vis, lives, level, clr, go;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Game-rule model: frog column kept as an index, death timing as cycles remaining.
    int m_st, m_row, m_ci, m_vis, m_lives, m_level, m_clr, m_go, m_dleft;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_row = 0; m_ci = SCOL; m_vis = 0; m_lives = LIVES;
        m_level = 0; m_clr = 1; m_go = 0; m_dleft = 0;
    endtask

    task automatic model_step(input bit s, input bit u, input bit d, input bit l,
                              input bit r, input bit b, input bit c);
        m_clr = 1;
        case (m_st)
            0, 6: if (s) begin
                m_st = 1; m_lives = LIVES; m_level = 0; m_clr = 0; m_go = 0;
            end
            1: if (b) m_st = 2;
            2: begin m_st = 3; m_row = 0; m_ci = SCOL; m_vis = 1; end
            3: begin
                if (c) begin
                    m_st = 4; m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    m_vis = 0; m_dleft = DWAIT;
                end else if (u) begin
                    m_row++;
                    if (m_row == ROWS - 1) m_st = 5;
                end else if (d) begin
                    if (m_row > 0) m_row--;
                end else if (l) begin
                    if (m_ci < DW - 1) m_ci++;
                end else if (r) begin
                    if (m_ci > 0) m_ci--;
                end
            end
            4: begin
                if (m_dleft == 1) begin
                    if (m_lives == 0) begin m_st = 6; m_go = 1; end
                    else m_st = 1;
                end else m_dleft--;
            end
            5: begin
                m_st = 1; m_level = (m_level < 15) ? m_level + 1 : 15; m_vis = 0; m_clr = 0;
            end
            default: m_st = 0;
        endcase
    endtask

    task automatic cyc(input bit s, input bit u, input bit d, input bit l,
                       input bit r, input bit b, input bit c);
        exp_t e;
        @(negedge clk);
        start_n = ~s; up_n = ~u; down_n = ~d; left_n = ~l; right_n = ~r;
        bottom = b; coll = c;
        model_step(s, u, d, l, r, b, c);
        e.st = m_st; e.row = m_row; e.col = 1 << m_ci; e.vis = m_vis;
        e.lives = m_lives; e.level = m_level; e.clr = m_clr; e.go = m_go;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(st_o), 0);
        chk({tag, "_row"}, 32'(row_o), 0);
        chk({tag, "_col"}, 32'(col_o), 32'h10);
        chk({tag, "_vis"}, 32'(vis_o), 0);
        chk({tag, "_lives"}, 32'(lives_o), 3);
        chk({tag, "_level"}, 32'(level_o), 0);
        chk({tag, "_clr"}, 32'(clr_n_o), 1);
        chk({tag, "_go"}, 32'(go_o), 0);
    endtask

    // Monitor: the DUT presents a new registered output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state", 32'(st_o), e.st);
                chk("row", 32'(row_o), e.row);
                chk("col", 32'(col_o), e.col);
                chk("visible", 32'(vis_o), e.vis);
                chk("lives", 32'(lives_o), e.lives);
                chk("level", 32'(level_o), e.level);
                chk("clearboard", 32'(clr_n_o), e.clr);
                chk("gameover", 32'(go_o), e.go);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Start with the bottom rows still occupied, then let it clear.
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);

        // Right edge saturation, down at row 0, up beats left.
        repeat (5) cyc(0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 1, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 1, 0);

        // Climb to the goal row from row 0.
        repeat (7) cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);

        // Lose every life; each collision carries a simultaneous move.
        repeat (LIVES) begin
            cyc(0, 0, 0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0, 1, 0);
            cyc(0, 1, 0, 0, 0, 1, 1);
            repeat (DWAIT) cyc(0, 0, 0, 0, 0, 1, 0);
        end
        repeat (3) cyc(0, 1, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);

        // Asynchronous reset in the middle of DEATH, between clock edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3000) begin
            cyc($urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 35,
                $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 4);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_frog_game_fsm.md
Name: sc_frog_game_fsm

Overview:
Top-level game sequencer for the Frogger datapath. It owns the frog position, lives and level, and walks the game through start, spawn, play, death, win and game-over. It gates frog spawning on the bottom-side-empty flag from the bottom-side comparator. It pulses the obstacle/board registers clear at game start and on each level win.

Parameters:
ROWS, 8, number of playfield rows; row 0 = bottom, row ROWS-1 = goal row.
DATAWIDTH, 8, number of playfield columns (width of the one-hot column bus).
START_COL, 4, column index loaded into the frog at spawn.
LIVES_INIT, 3, lives loaded at game start (1..3).
DEATH_WAIT, 25000000, cycles spent in DEATH (0.5 s at 50 MHz); benches override to 4.

Ports:
SC_FROGFSM_CLOCK_50  in  1  system clock, all state on rising edge
SC_FROGFSM_RESET_InLow  in  1  asynchronous active-low reset
SC_FROGFSM_start_InLow  in  1  start button, active-low level, debounced
SC_FROGFSM_up_InLow  in  1  active-low single-cycle move pulse
SC_FROGFSM_down_InLow  in  1  active-low single-cycle move pulse
SC_FROGFSM_left_InLow  in  1  active-low single-cycle move pulse
SC_FROGFSM_right_InLow  in  1  active-low single-cycle move pulse
SC_FROGFSM_bottomside_In  in  1  1 = bottom rows empty (comparator output)
SC_FROGFSM_collision_In  in  1  1 = obstacle overlaps frog at its current position
SC_FROGFSM_frogrow_Out  out  3  frog row index
SC_FROGFSM_frogcol_Out  out  DATAWIDTH  frog column, one-hot
SC_FROGFSM_frogvisible_Out  out  1  frog drawn when 1
SC_FROGFSM_lives_Out  out  2  remaining lives
SC_FROGFSM_level_Out  out  4  current level
SC_FROGFSM_clearboard_OutLow  out  1  active-low one-cycle board clear pulse
SC_FROGFSM_gameover_Out  out  1  1 while in GAMEOVER
SC_FROGFSM_state_Out  out  3  state encoding, debug

Behaviour:
- All outputs are registered. The reset is asynchronous and acts immediately, including mid-operation.
- Reset values:
  - state IDLE, row 0, col = one-hot(START_COL) (8'h10), visible 0.
  - lives LIVES_INIT, level 0.
  - clearboard 1, gameover 0.
  - death counter 0.
- State encoding: IDLE=0, WAITCLEAR=1, SPAWN=2, PLAY=3, DEATH=4, WIN=5, GAMEOVER=6. The unused code 7 goes to IDLE on the next edge.
- IDLE: when start_InLow==0, go to WAITCLEAR.
  - Reload lives=LIVES_INIT and level=0.
  - clearboard_OutLow=0 for exactly the first WAITCLEAR cycle.
- WAITCLEAR: stay while bottomside_In==0; there is no timeout. When bottomside_In==1, go to SPAWN.
- SPAWN: lasts exactly 1 cycle. Load row=0, col=one-hot(START_COL), visible=1, then go to PLAY.
- PLAY, evaluated each cycle in this priority order:
  - collision_In==1 → DEATH. Any move pulse in the same cycle is discarded and the position is held.
  - up: row+1. If the new row == ROWS-1, go to WIN; the row register shows ROWS-1.
  - down: row-1; ignored at row 0.
  - left: col shifted toward MSB; ignored when col[DATAWIDTH-1]=1.
  - right: col shifted toward LSB; ignored when col[0]=1.
  - Simultaneous pulses: at most one move per cycle, priority up > down > left > right.
- DEATH:
  - On entry: lives decremented (saturating at 0), visible=0, counter cleared.
  - Stays exactly DEATH_WAIT cycles; exits when counter==DEATH_WAIT-1.
  - Exit: lives==0 → GAMEOVER, otherwise → WAITCLEAR. No clearboard pulse on this path.
- WIN: lasts exactly 1 cycle.
  - level+1, saturating at 15; visible=0.
  - clearboard_OutLow=0 on the following (first WAITCLEAR) cycle, then go to WAITCLEAR.
- GAMEOVER: gameover_Out=1, visible=0. When start_InLow==0, behave as the IDLE start:
  - reload lives and level, clearboard pulse;
  - gameover_Out=0 from the WAITCLEAR cycle on.
- Inputs are used as-is (already synchronous and debounced). Move pulses outside PLAY are ignored. collision_In is ignored outside PLAY.
- Width rules:
  - frogrow_Out is 3 bits, sized for ROWS ≤ 8.
  - lives_Out is 2 bits, so LIVES_INIT ≤ 3.
  - The counter is wide enough for DEATH_WAIT (25 bits at the default).

Test Plan:
1. Reset; start_InLow low for 1 cycle, bottomside_In=1 → state 0→1→2→3 on consecutive edges; clearboard_OutLow=0 for exactly 1 cycle; in PLAY row=0, col=8'h10, visible=1, lives=3.
2. bottomside_In=0 for 10 cycles after start → state stays 1, visible=0; raise bottomside_In → PLAY 2 edges later.
3. In PLAY: right ×5 → col 8'h08, 8'h04, 8'h02, 8'h01, 8'h01; down at row 0 → row stays 0; up+left in the same cycle → row 1, col unchanged.
4. up ×7 from row 0 → after the 7th, row=7 and state=WIN; next edge level=1, visible=0, clearboard 0 for 1 cycle, state=WAITCLEAR.
5. DEATH_WAIT=4; collision with a simultaneous up → DEATH, row unchanged, lives 3→2, visible=0 for 4 cycles, then WAITCLEAR. Repeat to lives=0 → GAMEOVER, gameover_Out=1. Start → lives=3, level=0, gameover_Out=0, clearboard pulse.
6. Reset asserted asynchronously mid-DEATH (between edges) → all outputs at reset values before the next edge; state=IDLE.
